// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core pipeline.
package core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      FWD_ZERO,
      FWD_EX,
      FWD_MEM,
      FWD_WB,
      FWD_RF
   } fwd_sel_e;

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [REG_ADDR_W-1:0] rd_addr;
   } id_ex_t;

endpackage

// File: rtl/core_id_fwd_mux.sv
// Per-operand bypass selector: x0, then EX (non-load), MEM, WB, then register file.
module core_id_fwd_mux
   import core_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]       rf_data,
   input  logic                  ex_en,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_addr,
   input  logic [XLEN-1:0]       ex_data,
   input  logic                  mem_en,
   input  logic [REG_ADDR_W-1:0] mem_addr,
   input  logic [XLEN-1:0]       mem_data,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   output logic [XLEN-1:0]       data,
   output fwd_sel_e              sel
);

   always_comb begin
      sel = FWD_RF;
      if (addr == '0)
         sel = FWD_ZERO;
      else if (ex_en && !ex_is_load && ex_addr == addr)
         sel = FWD_EX;
      else if (mem_en && mem_addr == addr)
         sel = FWD_MEM;
      else if (wb_en && wb_addr == addr)
         sel = FWD_WB;
   end

   always_comb begin
      data = rf_data;
      case (sel)
         FWD_ZERO: data = '0;
         FWD_EX:   data = ex_data;
         FWD_MEM:  data = mem_data;
         FWD_WB:   data = wb_data;
         default:  data = rf_data;
      endcase
   end

endmodule

// File: rtl/core_id_ex_stage.sv
// Operand resolution, load-use hazard detection and the ID/EX pipeline register.
module core_id_ex_stage
   import core_pkg::*;
#(
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [31:0]       id_pc,
   input  logic [4:0]        id_rs1_addr,
   input  logic [4:0]        id_rs2_addr,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [4:0]        id_rd_addr,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [31:0]       rf_rs1_data,
   input  logic [31:0]       rf_rs2_data,
   input  logic              ex_fwd_en,
   input  logic              ex_fwd_is_load,
   input  logic [4:0]        ex_fwd_addr,
   input  logic [31:0]       ex_fwd_data,
   input  logic              mem_fwd_en,
   input  logic [4:0]        mem_fwd_addr,
   input  logic [31:0]       mem_fwd_data,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [31:0]       wb_data,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_imm,
   output logic [31:0]       ex_rs1_data,
   output logic [31:0]       ex_rs2_data,
   output logic [4:0]        ex_rd_addr,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              load_use_stall,
   output logic [31:0]       stall_cnt
);

   logic [XLEN-1:0] rs1_res, rs2_res;
   // Debug-only select codes; kept for waveform inspection.
   fwd_sel_e        rs1_sel_unused, rs2_sel_unused;
   id_ex_t          ex_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic            vld_q;

   core_id_fwd_mux u_fwd_rs1 (
      .addr(id_rs1_addr), .rf_data(rf_rs1_data),
      .ex_en(ex_fwd_en), .ex_is_load(ex_fwd_is_load), .ex_addr(ex_fwd_addr), .ex_data(ex_fwd_data),
      .mem_en(mem_fwd_en), .mem_addr(mem_fwd_addr), .mem_data(mem_fwd_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .data(rs1_res), .sel(rs1_sel_unused)
   );

   core_id_fwd_mux u_fwd_rs2 (
      .addr(id_rs2_addr), .rf_data(rf_rs2_data),
      .ex_en(ex_fwd_en), .ex_is_load(ex_fwd_is_load), .ex_addr(ex_fwd_addr), .ex_data(ex_fwd_data),
      .mem_en(mem_fwd_en), .mem_addr(mem_fwd_addr), .mem_data(mem_fwd_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .data(rs2_res), .sel(rs2_sel_unused)
   );

   // A load in EX has no data yet; a consumer must wait one cycle and pick it up from MEM.
   assign load_use_stall = id_valid && ex_fwd_en && ex_fwd_is_load && (ex_fwd_addr != '0) &&
                           ((id_rs1_used && ex_fwd_addr == id_rs1_addr) ||
                            (id_rs2_used && ex_fwd_addr == id_rs2_addr));

   assign id_ready = (!vld_q || ex_ready) && !load_use_stall && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         ex_q   <= '0;
         ctrl_q <= '0;
      end else if (flush) begin
         vld_q <= 1'b0;
      end else if (id_valid && id_ready) begin
         vld_q          <= 1'b1;
         ex_q.pc        <= id_pc;
         ex_q.imm       <= id_imm;
         ex_q.rs1_data  <= rs1_res;
         ex_q.rs2_data  <= rs2_res;
         ex_q.rd_addr   <= id_rd_addr;
         ctrl_q         <= id_ctrl;
      end else if (ex_ready) begin
         vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (load_use_stall && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign ex_valid    = vld_q;
   assign ex_pc       = ex_q.pc;
   assign ex_imm      = ex_q.imm;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_rd_addr  = ex_q.rd_addr;
   assign ex_ctrl     = ctrl_q;

endmodule
